// File: rtl/game_pkg.sv
// Shared types and constants for the labyrinth game-flow sequencer.
package game_pkg;

  localparam int STAGE_W    = 3;
  localparam int FRAME_RATE = 60;

  typedef enum logic [STAGE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WON  = 3'd3,
    ST_LOST = 3'd4
  } stage_e;

  localparam logic MSG_WIN  = 1'b0;
  localparam logic MSG_LOSE = 1'b1;

  function automatic logic is_end(stage_e s);
    return (s == ST_WON) || (s == ST_LOST);
  endfunction

endpackage

// File: rtl/game_flow_ctl_if.sv
// Signal bundle between the game-flow sequencer and the rest of the VGA game.
interface game_flow_ctl_if;
  import game_pkg::*;

  logic               vsync_in;
  logic               start;
  logic               goal_reached;
  logic               collision;
  logic [STAGE_W-1:0] stage;
  logic               freeze;
  logic               respawn;
  logic [1:0]         lives;
  logic               msg_enable;
  logic               msg_select;
  logic [6:0]         time_left;

  modport master (
    output vsync_in, start, goal_reached, collision,
    input  stage, freeze, respawn, lives, msg_enable, msg_select, time_left
  );

  modport slave (
    input  vsync_in, start, goal_reached, collision,
    output stage, freeze, respawn, lives, msg_enable, msg_select, time_left
  );

endinterface

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick per rising vsync edge; with GAME_TIMER_EN it also
// divides frame ticks down to one-second ticks while the game clock runs.
module frame_tick_gen
  import game_pkg::*;
`ifdef GAME_TIMER_EN
#(
  parameter int FRAMES_PER_SEC = FRAME_RATE
)
`endif
(
  input  logic pclk,
  input  logic rst,
  input  logic vsync_in,
`ifdef GAME_TIMER_EN
  input  logic sec_run,
  input  logic sec_clr,
  output logic sec_tick,
`endif
  output logic frame_tick
);

  logic vsync_q, vsync_d;
  logic armed_q, armed_d;

  always_comb begin
    vsync_d = vsync_in;
    armed_d = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      armed_q <= armed_d;
    end
  end

  // armed_q masks the first cycle after reset so a vsync already high does not tick
  assign frame_tick = armed_q && vsync_in && !vsync_q;

`ifdef GAME_TIMER_EN
  localparam int DIV_W = $clog2(FRAMES_PER_SEC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAMES_PER_SEC - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign sec_tick = sec_run && frame_tick && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (sec_clr)
      div_d = '0;
    else if (sec_run && frame_tick)
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge pclk) begin
    if (!rst) div_q <= '0;
    else      div_q <= div_d;
  end
`endif

endmodule

// File: rtl/game_flow_ctl.sv
// Top-level game sequencer: idle/play/hit/won/lost FSM, lives and hold timing.
// Optional countdown timer with timeout-to-LOST is built when GAME_TIMER_EN is defined.
module game_flow_ctl
  import game_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int FRAMES_PER_SEC  = FRAME_RATE,
  parameter int HIT_HOLD_FRAMES = 60,
  parameter int END_HOLD_FRAMES = 120,
  parameter int TIME_LIMIT      = 99
) (
  input  logic            pclk,
  input  logic            rst,
  game_flow_ctl_if.slave  bus
);

  if (LIVES < 1 || LIVES > 3 || HIT_HOLD_FRAMES < 1 || END_HOLD_FRAMES < 1 ||
      FRAMES_PER_SEC < 1 || TIME_LIMIT < 1 || TIME_LIMIT > 127) begin : g_bad_cfg
    $error("game_flow_ctl: parameter out of range");
  end

  localparam int HOLD_MAX = (HIT_HOLD_FRAMES > END_HOLD_FRAMES) ? HIT_HOLD_FRAMES
                                                                : END_HOLD_FRAMES;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HIT_LAST   = HOLD_W'(HIT_HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0] END_SAT    = HOLD_W'(END_HOLD_FRAMES);
  localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

  stage_e            state_q, state_d;
  logic [1:0]        lives_q, lives_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              respawn_q, respawn_d;
  logic              freeze_q, freeze_d;
  logic              msg_enable_q, msg_enable_d;
  logic              msg_select_q, msg_select_d;
  logic              frame_tick;

`ifdef GAME_TIMER_EN
  localparam logic [6:0] TIME_INIT = 7'(TIME_LIMIT);

  logic [6:0] time_left_q, time_left_d;
  logic       sec_run, sec_clr, sec_tick, expire;

  assign sec_run = (state_q == ST_PLAY) || (state_q == ST_HIT);
  assign expire  = sec_run && ((time_left_q == 7'd0) || (sec_tick && time_left_q == 7'd1));

  frame_tick_gen #(.FRAMES_PER_SEC(FRAMES_PER_SEC)) u_tick (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (bus.vsync_in),
    .sec_run    (sec_run),
    .sec_clr    (sec_clr),
    .sec_tick   (sec_tick),
    .frame_tick (frame_tick)
  );
`else
  frame_tick_gen u_tick (
    .pclk       (pclk),
    .rst        (rst),
    .vsync_in   (bus.vsync_in),
    .frame_tick (frame_tick)
  );
`endif

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    hold_d       = hold_q;
    respawn_d    = 1'b0;
    msg_select_d = msg_select_q;
`ifdef GAME_TIMER_EN
    sec_clr      = 1'b0;
    time_left_d  = time_left_q;
    if (sec_run && sec_tick && time_left_q != 7'd0)
      time_left_d = time_left_q - 7'd1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_INIT;
          respawn_d = 1'b1;
          hold_d    = '0;
`ifdef GAME_TIMER_EN
          time_left_d = TIME_INIT;
          sec_clr     = 1'b1;
`endif
        end
      end

      ST_PLAY: begin
        if (bus.goal_reached) begin
          state_d      = ST_WON;
          msg_select_d = MSG_WIN;
          hold_d       = '0;
        end
`ifdef GAME_TIMER_EN
        else if (expire) begin
          state_d      = ST_LOST;
          msg_select_d = MSG_LOSE;
          hold_d       = '0;
        end
`endif
        // while the respawn pulse is out the user is still being moved back to start
        else if (bus.collision && !respawn_q) begin
          hold_d = '0;
          if (lives_q > 2'd1) begin
            state_d   = ST_HIT;
            lives_d   = lives_q - 2'd1;
            respawn_d = 1'b1;
          end else begin
            state_d      = ST_LOST;
            lives_d      = 2'd0;
            msg_select_d = MSG_LOSE;
          end
        end
      end

      ST_HIT: begin
`ifdef GAME_TIMER_EN
        if (expire) begin
          state_d      = ST_LOST;
          msg_select_d = MSG_LOSE;
          hold_d       = '0;
        end else
`endif
        if (frame_tick) begin
          if (hold_q == HIT_LAST) begin
            state_d = ST_PLAY;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end

      ST_WON, ST_LOST: begin
        if (bus.start && hold_q == END_SAT) begin
          state_d   = ST_PLAY;
          lives_d   = LIVES_INIT;
          respawn_d = 1'b1;
          hold_d    = '0;
`ifdef GAME_TIMER_EN
          time_left_d = TIME_INIT;
          sec_clr     = 1'b1;
`endif
        end else if (frame_tick && hold_q != END_SAT) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    freeze_d     = (state_d != ST_PLAY);
    msg_enable_d = is_end(state_d);
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lives_q      <= 2'd0;
      hold_q       <= '0;
      respawn_q    <= 1'b0;
      freeze_q     <= 1'b1;
      msg_enable_q <= 1'b0;
      msg_select_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      hold_q       <= hold_d;
      respawn_q    <= respawn_d;
      freeze_q     <= freeze_d;
      msg_enable_q <= msg_enable_d;
      msg_select_q <= msg_select_d;
    end
  end

`ifdef GAME_TIMER_EN
  always_ff @(posedge pclk) begin
    if (!rst) time_left_q <= 7'd0;
    else      time_left_q <= time_left_d;
  end
  assign bus.time_left = time_left_q;
`else
  assign bus.time_left = 7'd0;
`endif

  assign bus.stage      = state_q;
  assign bus.lives      = lives_q;
  assign bus.respawn    = respawn_q;
  assign bus.freeze     = freeze_q;
  assign bus.msg_enable = msg_enable_q;
  assign bus.msg_select = msg_select_q;

endmodule
